// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums N_PIXELS signed products plus a bias with saturation,
// then hands the pre-activation sum and a cat/not-cat decision downstream.
module neuron_accumulator #(
    parameter int N_PIXELS = 12288,
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 48,
    parameter int CNT_W    = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       bias,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              is_cat,
    output logic              overflow,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, DONE} state_t;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_PIXELS - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, sum_q, sum_d, addend, raw, sat;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, cat_q, cat_d, add_ovf;
    // One shared saturating adder: products in ACCUM, the bias in BIAS
    always_comb begin
        addend  = (state_q == BIAS) ? ACC_W'($signed(bias)) : ACC_W'($signed(prod));
        raw     = acc_q + addend;
        add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc_q[ACC_W-1]);
        sat     = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw;
    end
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        cat_d   = cat_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                state_d = ACCUM;
            end
            ACCUM: if (prod_valid) begin
                acc_d   = sat;
                ovf_d   = ovf_q | add_ovf;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == LAST) ? BIAS : ACCUM;
            end
            BIAS: begin
                acc_d   = sat;
                ovf_d   = ovf_q | add_ovf;
                sum_d   = sat;
                cat_d   = !sat[ACC_W-1] && (|sat);
                state_d = DONE;
            end
            default: state_d = result_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            cat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            cat_q   <= cat_d;
        end
    end
    assign prod_ready   = (state_q == ACCUM);
    assign result_valid = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign sum          = sum_q;
    assign is_cat       = cat_q;
    assign overflow     = ovf_q;
endmodule

// File: tb/tb_neuron_accumulator.sv
// tb_neuron_accumulator: directed tests on three instances (N=4/48b, N=4/34b, N=1).
module tb_neuron_accumulator;
    logic clk = 0, rst = 0, bias_unused = 0;
    logic start_a = 0, start_b = 0, start_c = 0;
    logic [31:0] bias = 0, prod = 0;
    logic prod_valid = 0, result_ready = 0;
    logic pr_a, rv_a, cat_a, ovf_a, busy_a;
    logic pr_b, rv_b, cat_b, ovf_b, busy_b;
    logic pr_c, rv_c, cat_c, ovf_c, busy_c;
    logic [47:0] sum_a, sum_c;
    logic [33:0] sum_b;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(.N_PIXELS(4), .PROD_W(32), .ACC_W(48), .CNT_W(14)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bias(bias), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(pr_a), .result_valid(rv_a), .result_ready(result_ready), .sum(sum_a),
        .is_cat(cat_a), .overflow(ovf_a), .busy(busy_a));
    neuron_accumulator #(.N_PIXELS(4), .PROD_W(32), .ACC_W(34), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bias(bias), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(pr_b), .result_valid(rv_b), .result_ready(result_ready), .sum(sum_b),
        .is_cat(cat_b), .overflow(ovf_b), .busy(busy_b));
    neuron_accumulator #(.N_PIXELS(1), .PROD_W(32), .ACC_W(48), .CNT_W(1)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bias(bias), .prod_valid(prod_valid), .prod(prod),
        .prod_ready(pr_c), .result_valid(rv_c), .result_ready(result_ready), .sum(sum_c),
        .is_cat(cat_c), .overflow(ovf_c), .busy(busy_c));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts one instance and streams n products back-to-back; returns in BIAS at a negedge
    task automatic feed(input int which, input logic [31:0] b, input logic [31:0] p0,
                        input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3, input int n);
        logic [31:0] p [4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        bias = b;
        start_a = (which == 0); start_b = (which == 1); start_c = (which == 2);
        step();
        start_a = 0; start_b = 0; start_c = 0;
        for (int i = 0; i < n; i++) begin
            prod_valid = 1; prod = p[i];
            step();
        end
        prod_valid = 0;
    endtask

    task automatic ack();
        result_ready = 1;
        step();
        result_ready = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        step(); step();
        n_cmp += 6;
        if (busy_a !== 0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        if (pr_a !== 0) begin n_bad++; $display("FAIL reset_prod_ready: got %b want 0", pr_a); end
        if (rv_a !== 0) begin n_bad++; $display("FAIL reset_result_valid: got %b want 0", rv_a); end
        if (sum_a !== 48'd0) begin n_bad++; $display("FAIL reset_sum: got %0d want 0", $signed(sum_a)); end
        if (cat_a !== 0) begin n_bad++; $display("FAIL reset_is_cat: got %b want 0", cat_a); end
        if (ovf_a !== 0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", ovf_a); end
        rst = 1;
        step();
    endtask

    task automatic test_basic();
        feed(0, 0, 100, -50, 25, 5, 4);
        n_cmp += 3;
        if (pr_a !== 0) begin n_bad++; $display("FAIL basic_bias_ready: got %b want 0", pr_a); end
        if (rv_a !== 0) begin n_bad++; $display("FAIL basic_bias_valid: got %b want 0", rv_a); end
        if (busy_a !== 1) begin n_bad++; $display("FAIL basic_bias_busy: got %b want 1", busy_a); end
        step();
        n_cmp += 4;
        if (rv_a !== 1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", rv_a); end
        if (sum_a !== 48'(80)) begin n_bad++; $display("FAIL basic_sum: got %0d want 80", $signed(sum_a)); end
        if (cat_a !== 1) begin n_bad++; $display("FAIL basic_cat: got %b want 1", cat_a); end
        if (ovf_a !== 0) begin n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf_a); end
        ack();
        n_cmp += 3;
        if (rv_a !== 0) begin n_bad++; $display("FAIL basic_ack_valid: got %b want 0", rv_a); end
        if (busy_a !== 0) begin n_bad++; $display("FAIL basic_ack_busy: got %b want 0", busy_a); end
        if (sum_a !== 48'(80)) begin n_bad++; $display("FAIL basic_idle_sum: got %0d want 80", $signed(sum_a)); end
    endtask

    task automatic test_bias();
        int b [3] = '{-80, -200, 20};
        int s [3] = '{0, -120, 100};
        logic c [3] = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            feed(0, b[i], 100, -50, 25, 5, 4);
            step();
            n_cmp += 2;
            if (sum_a !== 48'(s[i])) begin n_bad++; $display("FAIL bias%0d_sum: got %0d want %0d", i, $signed(sum_a), s[i]); end
            if (cat_a !== c[i]) begin n_bad++; $display("FAIL bias%0d_cat: got %b want %b", i, cat_a, c[i]); end
            ack();
        end
    endtask

    task automatic test_stall();
        logic pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        logic [31:0] pv [4] = '{10, 20, 30, 40};
        int k = 0;
        bias = 0; start_a = 1;
        step();
        start_a = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                n_cmp++;
                if (pr_a !== 1) begin n_bad++; $display("FAIL stall_still_accum: got %b want 1", pr_a); end
            end
            prod_valid = pat[i];
            prod = pat[i] ? pv[k] : 32'd999;
            if (pat[i]) k++;
            step();
        end
        prod = 1000;
        n_cmp++;
        if (pr_a !== 0) begin n_bad++; $display("FAIL stall_bias_ready: got %b want 0", pr_a); end
        step();
        n_cmp += 3;
        if (rv_a !== 1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", rv_a); end
        if (pr_a !== 0) begin n_bad++; $display("FAIL stall_done_ready: got %b want 0", pr_a); end
        if (sum_a !== 48'(100)) begin n_bad++; $display("FAIL stall_sum: got %0d want 100", $signed(sum_a)); end
        step();
        n_cmp++;
        if (sum_a !== 48'(100)) begin n_bad++; $display("FAIL stall_sum_hold: got %0d want 100", $signed(sum_a)); end
        prod_valid = 0;
        ack();
    endtask

    task automatic test_back_to_back();
        feed(0, 0, 1, 2, 3, 4, 4);
        step();
        for (int i = 0; i < 5; i++) begin
            start_a = 1;
            step();
            n_cmp++;
            if (rv_a !== 1 || sum_a !== 48'(10) || cat_a !== 1) begin
                n_bad++;
                $display("FAIL backpressure_hold%0d: got valid=%b sum=%0d cat=%b want 1/10/1", i, rv_a, $signed(sum_a), cat_a);
            end
        end
        result_ready = 1;
        step();
        start_a = 0; result_ready = 0;
        n_cmp += 2;
        if (busy_a !== 0) begin n_bad++; $display("FAIL start_with_ack_ignored: got busy=%b want 0", busy_a); end
        if (sum_a !== 48'(10)) begin n_bad++; $display("FAIL backpressure_idle_sum: got %0d want 10", $signed(sum_a)); end
        feed(0, 2, 7, 7, 7, 7, 4);
        step();
        n_cmp++;
        if (sum_a !== 48'(30)) begin n_bad++; $display("FAIL next_image_sum: got %0d want 30", $signed(sum_a)); end
        ack();
    endtask

    task automatic test_saturation();
        feed(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4);
        n_cmp++;
        if (ovf_b !== 0) begin n_bad++; $display("FAIL sat_prebias_ovf: got %b want 0", ovf_b); end
        step();
        n_cmp += 3;
        if (sum_b !== 34'h1_FFFF_FFFF) begin n_bad++; $display("FAIL sat_pos_sum: got %h want 1ffffffff", sum_b); end
        if (ovf_b !== 1) begin n_bad++; $display("FAIL sat_pos_ovf: got %b want 1", ovf_b); end
        if (cat_b !== 1) begin n_bad++; $display("FAIL sat_pos_cat: got %b want 1", cat_b); end
        ack();
        n_cmp++;
        if (ovf_b !== 1) begin n_bad++; $display("FAIL sat_ovf_sticky: got %b want 1", ovf_b); end
        feed(1, -5, 1, 1, 1, 1, 4);
        step();
        n_cmp += 3;
        if (sum_b !== 34'(-1)) begin n_bad++; $display("FAIL sat_clear_sum: got %0d want -1", $signed(sum_b)); end
        if (ovf_b !== 0) begin n_bad++; $display("FAIL sat_clear_ovf: got %b want 0", ovf_b); end
        if (cat_b !== 0) begin n_bad++; $display("FAIL sat_clear_cat: got %b want 0", cat_b); end
        ack();
        feed(1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4);
        step();
        n_cmp += 3;
        if (sum_b !== 34'h2_0000_0000) begin n_bad++; $display("FAIL sat_neg_sum: got %h want 200000000", sum_b); end
        if (ovf_b !== 1) begin n_bad++; $display("FAIL sat_neg_ovf: got %b want 1", ovf_b); end
        if (cat_b !== 0) begin n_bad++; $display("FAIL sat_neg_cat: got %b want 0", cat_b); end
        ack();
    endtask

    task automatic test_abort();
        bias = 0; start_a = 1;
        step();
        start_a = 0; prod_valid = 1; prod = 500;
        step(); step();
        n_cmp++;
        if (busy_a !== 1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy_a); end
        rst = 0;
        #1;
        n_cmp += 4;
        if (busy_a !== 0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_a); end
        if (pr_a !== 0) begin n_bad++; $display("FAIL abort_prod_ready: got %b want 0", pr_a); end
        if (sum_a !== 48'd0) begin n_bad++; $display("FAIL abort_sum: got %0d want 0", $signed(sum_a)); end
        if (rv_a !== 0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", rv_a); end
        prod_valid = 0;
        @(negedge clk);
        rst = 1;
        step();
        feed(0, 3, 5, 6, 7, 8, 4);
        step();
        n_cmp++;
        if (sum_a !== 48'(29)) begin n_bad++; $display("FAIL abort_next_sum: got %0d want 29", $signed(sum_a)); end
        ack();
    endtask

    task automatic test_single();
        feed(2, 10, -7, 0, 0, 0, 1);
        n_cmp += 2;
        if (pr_c !== 0) begin n_bad++; $display("FAIL single_bias_ready: got %b want 0", pr_c); end
        if (rv_c !== 0) begin n_bad++; $display("FAIL single_bias_valid: got %b want 0", rv_c); end
        step();
        n_cmp += 2;
        if (sum_c !== 48'(3)) begin n_bad++; $display("FAIL single_sum: got %0d want 3", $signed(sum_c)); end
        if (cat_c !== 1) begin n_bad++; $display("FAIL single_cat: got %b want 1", cat_c); end
        ack();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_bias();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_abort();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
